// File: rtl/blink_sequencer_if.sv
// Event handshake between the game-logic FSM and the blink sequencer.
interface blink_sequencer_if #(
    parameter int CODE_W = 3
);
    logic              event_valid;
    logic [CODE_W-1:0] event_code;
    logic              event_ready;

    modport master (
        output event_valid,
        output event_code,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_code,
        output event_ready
    );
endinterface

// File: rtl/blink_sequencer.sv
// Buffers blink-count events and plays each on one LED as timed blinks.
module blink_sequencer #(
    parameter int TICK_DIV   = 2500000,
    parameter int ON_TICKS   = 4,
    parameter int OFF_TICKS  = 4,
    parameter int GAP_TICKS  = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int CODE_W     = 3
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    blink_sequencer_if.slave  ev,
    output logic              led,
    output logic              busy,
    output logic              dropped
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TW    = $clog2(TICK_DIV);
    localparam int MAX1  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAXT  = (MAX1 > GAP_TICKS) ? MAX1 : GAP_TICKS;
    localparam int PW    = $clog2(MAXT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PTR_W:0]  CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [TW-1:0]   TICK_ONE  = TW'(1);
    localparam logic [PW-1:0]   PH_ONE    = PW'(1);
    localparam logic [CODE_W-1:0] REM_ONE = CODE_W'(1);

    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [PW-1:0]     ph_q, ph_d;
    logic [PW-1:0]     ph_lim;
    logic [CODE_W-1:0] rem_q, rem_d;
    logic              led_q, led_d;
    logic              drop_q, drop_d;

    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [PTR_W:0]    cnt_q, cnt_d;

    logic full, empty, push_req, push, pop, tick, done;

    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign push_req = ev.event_valid && (ev.event_code != '0);
    // Fullness uses the pre-edge count, so a same-edge pop never frees space.
    assign push     = push_req && !full;
    assign pop      = (state_q == S_IDLE) && !empty;
    assign drop_d   = push_req && full;
    assign tick     = (tick_q == TICK_LAST);
    assign done     = tick && (ph_q == ph_lim);

    always_comb begin
        ph_lim = '0;
        unique case (state_q)
            S_ON:    ph_lim = PW'(ON_TICKS - 1);
            S_OFF:   ph_lim = PW'(OFF_TICKS - 1);
            S_GAP:   ph_lim = PW'(GAP_TICKS - 1);
            default: ph_lim = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_ON;
                    led_d   = 1'b1;
                    rem_d   = mem_q[rptr_q];
                end
            end
            S_ON: begin
                if (done) begin
                    led_d   = 1'b0;
                    rem_d   = rem_q - REM_ONE;
                    state_d = (rem_q == REM_ONE) ? S_GAP : S_OFF;
                end
            end
            S_OFF: begin
                if (done) begin
                    state_d = S_ON;
                    led_d   = 1'b1;
                end
            end
            S_GAP: begin
                if (done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timer restarts on every state entry so each phase is exactly N ticks.
    always_comb begin
        tick_d = '0;
        ph_d   = '0;
        if ((state_d == state_q) && (state_q != S_IDLE)) begin
            tick_d = tick ? '0 : tick_q + TICK_ONE;
            ph_d   = tick ? ph_q + PH_ONE : ph_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            ph_q    <= '0;
            rem_q   <= '0;
            led_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            ph_q    <= ph_d;
            rem_q   <= rem_d;
            led_q   <= led_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                mem_q[wptr_q] <= ev.event_code;
                wptr_q        <= wptr_q + PTR_ONE;
            end
            if (pop) rptr_q <= rptr_q + PTR_ONE;
        end
    end

    assign led            = led_q;
    assign dropped        = drop_q;
    assign busy           = (state_q != S_IDLE) || !empty;
    assign ev.event_ready = !full;

endmodule
